// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises instruction fetch and data access onto one
// variable-latency memory, data first, with a bounded number of data grants while fetch waits.
module mem_arbiter #(
  parameter int ADDR_W      = 64,
  parameter int DATA_W      = 64,
  parameter int INST_W      = 32,
  parameter int MAX_D_BURST = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [INST_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              stall_if,
  output logic              stall_mem,
  output logic [1:0]        owner
);

  localparam int CNT_W = $clog2(MAX_D_BURST + 1);
  localparam logic [CNT_W-1:0] BURST_MAX = CNT_W'(MAX_D_BURST);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] burst_cnt;
  logic             fetch_starved;
  logic             grant_d, grant_i, done_i, done_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == BURST_MAX) ? v : v + 1'b1;
  endfunction

  assign fetch_starved = if_req && (burst_cnt == BURST_MAX);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (d_req && !fetch_starved) state_nxt = D_BUSY;
        else if (if_req)             state_nxt = I_BUSY;
      end
      I_BUSY, D_BUSY: if (mem_ready) state_nxt = DONE;
      DONE:           state_nxt = IDLE;
      default:        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    grant_d = (state == IDLE) && (state_nxt == D_BUSY);
    grant_i = (state == IDLE) && (state_nxt == I_BUSY);
    done_i  = (state == I_BUSY) && mem_ready;
    done_d  = (state == D_BUSY) && mem_ready;
  end

  // Memory side is driven only from these latches, so requesters may change after grant
  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      owner     <= 2'b00;
    end else begin
      if_ack <= done_i;
      d_ack  <= done_d;
      if (grant_d) begin
        mem_req   <= 1'b1;
        mem_we    <= d_we;
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        owner     <= 2'b10;
        burst_cnt <= if_req ? sat_inc(burst_cnt) : '0;
      end
      if (grant_i) begin
        mem_req   <= 1'b1;
        mem_we    <= 1'b0;
        mem_addr  <= if_addr;
        owner     <= 2'b01;
        burst_cnt <= '0;
      end
      if (done_i || done_d) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end
      if (done_i)            if_rdata <= mem_rdata[INST_W-1:0];
      if (done_d && !mem_we) d_rdata  <= mem_rdata;
      if (state == DONE)     owner    <= 2'b00;
    end
  end

  assign stall_if  = if_req & ~if_ack;
  assign stall_mem = d_req & ~d_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single fetch, contention, fairness,
// store with wait states and reset in the middle of an access.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [63:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [63:0] d_addr;
  logic [63:0] d_wdata;
  logic        d_ack;
  logic [63:0] d_rdata;
  logic        mem_req;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;
  logic        stall_if;
  logic        stall_mem;
  logic [1:0]  owner;

  int checks = 0;
  int errors = 0;

  mem_arbiter #(.ADDR_W(64), .DATA_W(64), .INST_W(32), .MAX_D_BURST(2)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_if(stall_if), .stall_mem(stall_mem), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; if_req = 1'b1; d_req = 1'b1; mem_ready = 1'b1;
    if_addr = 64'h0; d_we = 1'b0; d_addr = 64'h40; d_wdata = 64'h0;
    mem_rdata = 64'h0000_0000_0000_1234;
    next_cycle(); next_cycle(); settle();
    checks++; if (mem_req !== 1'b0)   begin errors++; $display("FAIL reset_mem_req: got %b expected 0", mem_req); end
    checks++; if (mem_we !== 1'b0)    begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
    checks++; if (mem_addr !== 64'h0) begin errors++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
    checks++; if (mem_wdata !== 64'h0) begin errors++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
    checks++; if ({if_ack, d_ack} !== 2'b00) begin errors++; $display("FAIL reset_acks: got %b expected 00", {if_ack, d_ack}); end
    checks++; if (if_rdata !== 32'h0) begin errors++; $display("FAIL reset_if_rdata: got %h expected 0", if_rdata); end
    checks++; if (d_rdata !== 64'h0)  begin errors++; $display("FAIL reset_d_rdata: got %h expected 0", d_rdata); end
    checks++; if (owner !== 2'b00)    begin errors++; $display("FAIL reset_owner: got %b expected 00", owner); end
    rst = 1'b0;
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b1 || owner !== 2'b10) begin errors++; $display("FAIL reset_first_grant: got req=%b owner=%b expected req=1 owner=10", mem_req, owner); end
    checks++; if (mem_addr !== 64'h40) begin errors++; $display("FAIL reset_first_addr: got %h expected 40", mem_addr); end
    next_cycle(); settle();
    checks++; if (d_ack !== 1'b1 || d_rdata !== 64'h1234) begin errors++; $display("FAIL reset_first_ack: got ack=%b rdata=%h expected ack=1 rdata=1234", d_ack, d_rdata); end
    if_req = 1'b0; d_req = 1'b0;
    next_cycle(); next_cycle();
  endtask

  task automatic test_single_fetch();
    if_req = 1'b1; if_addr = 64'h10; mem_ready = 1'b1;
    mem_rdata = 64'hAAAA_BBBB_0000_0013;
    settle();
    checks++; if (mem_req !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL fetch_c0: got req=%b stall_if=%b expected req=0 stall_if=1", mem_req, stall_if); end
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b1 || owner !== 2'b01 || mem_we !== 1'b0) begin errors++; $display("FAIL fetch_c1_grant: got req=%b owner=%b we=%b expected 1 01 0", mem_req, owner, mem_we); end
    checks++; if (mem_addr !== 64'h10 || stall_if !== 1'b1 || if_ack !== 1'b0) begin errors++; $display("FAIL fetch_c1_state: got addr=%h stall_if=%b ack=%b expected 10 1 0", mem_addr, stall_if, if_ack); end
    next_cycle(); settle();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0000_0013) begin errors++; $display("FAIL fetch_c2_ack: got ack=%b rdata=%h expected 1 00000013", if_ack, if_rdata); end
    checks++; if (stall_if !== 1'b0 || mem_req !== 1'b0 || owner !== 2'b01) begin errors++; $display("FAIL fetch_c2_state: got stall_if=%b req=%b owner=%b expected 0 0 01", stall_if, mem_req, owner); end
    if_req = 1'b0;
    next_cycle(); settle();
    checks++; if (if_ack !== 1'b0 || owner !== 2'b00 || if_rdata !== 32'h13) begin errors++; $display("FAIL fetch_c3_idle: got ack=%b owner=%b rdata=%h expected 0 00 13", if_ack, owner, if_rdata); end
    next_cycle();
  endtask

  task automatic test_contention();
    if_req = 1'b1; if_addr = 64'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h100;
    mem_ready = 1'b1; mem_rdata = 64'h1111_2222_3333_CAFE;
    next_cycle(); settle();
    checks++; if (owner !== 2'b10 || mem_addr !== 64'h100 || stall_if !== 1'b1) begin errors++; $display("FAIL cont_data_first: got owner=%b addr=%h stall_if=%b expected 10 100 1", owner, mem_addr, stall_if); end
    next_cycle(); settle();
    checks++; if (d_ack !== 1'b1 || d_rdata !== 64'h1111_2222_3333_CAFE || if_ack !== 1'b0 || stall_if !== 1'b1) begin errors++; $display("FAIL cont_data_ack: got d_ack=%b rdata=%h if_ack=%b stall_if=%b", d_ack, d_rdata, if_ack, stall_if); end
    d_req = 1'b0; mem_rdata = 64'h9999_8888_0000_0517;
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b0 || owner !== 2'b00 || stall_if !== 1'b1) begin errors++; $display("FAIL cont_idle: got req=%b owner=%b stall_if=%b expected 0 00 1", mem_req, owner, stall_if); end
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b1 || owner !== 2'b01 || mem_addr !== 64'h200) begin errors++; $display("FAIL cont_fetch_grant: got req=%b owner=%b addr=%h expected 1 01 200", mem_req, owner, mem_addr); end
    next_cycle(); settle();
    checks++; if (if_ack !== 1'b1 || if_rdata !== 32'h0000_0517) begin errors++; $display("FAIL cont_fetch_ack: got ack=%b rdata=%h expected 1 00000517", if_ack, if_rdata); end
    if_req = 1'b0;
    next_cycle(); next_cycle();
  endtask

  task automatic test_store_wait();
    d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20; d_wdata = 64'h55;
    mem_ready = 1'b0; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    for (int i = 1; i <= 4; i++) begin
      next_cycle();
      if (i == 1) begin d_addr = 64'h999; d_wdata = 64'h77; end
      if (i == 4) mem_ready = 1'b1;
      settle();
      checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 64'h20 || mem_wdata !== 64'h55) begin errors++; $display("FAIL store_hold_%0d: got req=%b we=%b addr=%h wdata=%h expected 1 1 20 55", i, mem_req, mem_we, mem_addr, mem_wdata); end
      checks++; if (d_ack !== 1'b0 || stall_mem !== 1'b1) begin errors++; $display("FAIL store_wait_%0d: got ack=%b stall_mem=%b expected 0 1", i, d_ack, stall_mem); end
    end
    next_cycle(); settle();
    checks++; if (d_ack !== 1'b1 || stall_mem !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL store_ack: got ack=%b stall_mem=%b req=%b expected 1 0 0", d_ack, stall_mem, mem_req); end
    checks++; if (d_rdata !== 64'h1111_2222_3333_CAFE) begin errors++; $display("FAIL store_rdata_kept: got %h expected 1111222233 33cafe", d_rdata); end
    d_req = 1'b0; mem_ready = 1'b0;
    next_cycle(); settle();
    checks++; if (d_ack !== 1'b0) begin errors++; $display("FAIL store_ack_pulse: got %b expected 0", d_ack); end
    next_cycle();
  endtask

  task automatic test_fairness();
    logic [1:0] exp_owner [6];
    exp_owner = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01};
    if_req = 1'b1; if_addr = 64'h300;
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h400;
    mem_ready = 1'b1; mem_rdata = 64'h0;
    for (int g = 0; g < 6; g++) begin
      next_cycle(); settle();
      checks++; if (mem_req !== 1'b1 || owner !== exp_owner[g]) begin errors++; $display("FAIL fair_grant_%0d: got req=%b owner=%b expected req=1 owner=%b", g, mem_req, owner, exp_owner[g]); end
      checks++; if (mem_addr !== ((exp_owner[g] == 2'b01) ? 64'h300 : 64'h400)) begin errors++; $display("FAIL fair_addr_%0d: got %h", g, mem_addr); end
      next_cycle(); settle();
      checks++; if ({if_ack, d_ack} !== ((exp_owner[g] == 2'b01) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL fair_ack_%0d: got if_ack=%b d_ack=%b", g, if_ack, d_ack); end
      if (g == 5) begin if_req = 1'b0; d_req = 1'b0; end
      next_cycle();
    end
    settle();
    checks++; if (mem_req !== 1'b0 || owner !== 2'b00) begin errors++; $display("FAIL fair_end_idle: got req=%b owner=%b expected 0 00", mem_req, owner); end
    next_cycle();
  endtask

  task automatic test_mid_reset();
    if_req = 1'b1; if_addr = 64'h500; mem_ready = 1'b0; mem_rdata = 64'h0000_0000_1234_5678;
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b1 || owner !== 2'b01) begin errors++; $display("FAIL midrst_grant: got req=%b owner=%b expected 1 01", mem_req, owner); end
    next_cycle();
    rst = 1'b1;
    next_cycle();
    rst = 1'b0; if_req = 1'b0; mem_ready = 1'b1;
    settle();
    checks++; if (mem_req !== 1'b0 || owner !== 2'b00 || if_rdata !== 32'h0 || d_rdata !== 64'h0) begin errors++; $display("FAIL midrst_cleared: got req=%b owner=%b if_rdata=%h d_rdata=%h", mem_req, owner, if_rdata, d_rdata); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (if_ack !== 1'b0 || mem_req !== 1'b0) begin errors++; $display("FAIL midrst_no_ack_%0d: got ack=%b req=%b expected 0 0", i, if_ack, mem_req); end
      next_cycle(); settle();
    end
    d_req = 1'b1; d_we = 1'b0; d_addr = 64'h600;
    next_cycle(); settle();
    checks++; if (mem_req !== 1'b1 || owner !== 2'b10 || mem_addr !== 64'h600) begin errors++; $display("FAIL midrst_idle_regrant: got req=%b owner=%b addr=%h expected 1 10 600", mem_req, owner, mem_addr); end
    next_cycle();
    d_req = 1'b0;
    next_cycle(); next_cycle();
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_contention();
    test_store_wait();
    test_fairness();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and sequencer that lets the IF stage (instruction fetch) and the MEM stage (load/store) share one unified memory with variable latency. It serialises the two requesters through a small FSM and gives data accesses priority, with a bounded-starvation guarantee for fetch. It produces per-stage stall signals consumed by the pipeline registers and the hazard unit.

## Interface
- ADDR_W, 64, address width, byte address passed through unchanged
- DATA_W, 64, memory data width
- INST_W, 32, instruction width; low INST_W bits of memory read data
- MAX_D_BURST, 4, max consecutive data grants while fetch is waiting; must be ≥1

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request, level; held with if_addr until if_ack
- if_addr  in  ADDR_W  fetch address
- if_ack  out  1  one-cycle completion pulse
- if_rdata  out  INST_W  fetched instruction, registered, valid with if_ack and held until next fetch completes
- d_req  in  1  data request, level; held with d_we/d_addr/d_wdata until d_ack
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_ack  out  1  one-cycle completion pulse
- d_rdata  out  DATA_W  load data, registered, valid with d_ack, held until next load completes
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid when mem_ready
- mem_ready  in  1  memory completes current access this cycle
- stall_if  out  1  if_req & ~if_ack
- stall_mem  out  1  d_req & ~d_ack
- owner  out  2  00 none, 01 fetch, 10 data

## Operation
- FSM states: IDLE, I_BUSY, D_BUSY, DONE.
- IDLE: if d_req and not (if_req and burst_cnt == MAX_D_BURST) → D_BUSY; else if if_req → I_BUSY; else stay.
- On grant, latch addr (and we/wdata for data) into internal registers; mem_* driven from latches only, so requester changes after grant have no effect.
- burst_cnt: on data grant, if if_req=1 then increment (saturate at MAX_D_BURST) else clear; on fetch grant clear.
- I_BUSY/D_BUSY: mem_req=1, mem_we = latched we (always 0 in I_BUSY), owner = 01/10. When mem_ready=1: capture mem_rdata (fetch: low INST_W bits into if_rdata; load: into d_rdata; store: d_rdata unchanged), → DONE with matching ack set.
- DONE: exactly one of if_ack/d_ack = 1, mem_req=0, owner keeps last value; unconditional → IDLE. Requester must drop or replace its request at the DONE edge.
- mem_ready outside busy states is ignored.
- stall_if/stall_mem combinational from req and ack; all other outputs registered.

## Timing
- Reset: state IDLE, burst_cnt 0, mem_req/mem_we 0, mem_addr/mem_wdata 0, if_ack/d_ack 0, if_rdata/d_rdata 0, owner 00.
- Zero-wait access: req seen in IDLE cycle N → mem_req cycle N+1, mem_ready in N+1 → ack cycle N+2 → IDLE N+3. Back-to-back requests: one every 3 cycles, each wait state adds 1.
- Simultaneous if_req and d_req in IDLE: data wins unless fairness limit reached.
- rst during busy/DONE: access abandoned, no ack issued, mem_req low the following cycle; capture registers cleared.
- mem_req never asserted in the same cycle a request first appears (always one IDLE decision cycle).

## Test plan
- Reset: hold rst 2 cycles with if_req=1, d_req=1, mem_ready=1 → all outputs 0, owner=00; first grant (data) appears cycle after rst drops.
- Single fetch: if_addr=0x10, mem_ready tied 1, mem_rdata=0xAAAA_BBBB_0000_0013 → mem_req cycle 1, if_ack cycle 2 with if_rdata=0x0000_0013, stall_if 1 in cycles 0–1, 0 in cycle 2.
- Contention: if_req and d_req (load 0x100) rise together → data served first (owner=10), fetch granted in the IDLE cycle after DONE; stall_if high throughout data access.
- Fairness, MAX_D_BURST=2: if_req held, d_req re-asserted every cycle → grant order D, D, I, D, D, I; burst_cnt resets after fetch grant.
- Wait states and store: store d_addr=0x20, d_wdata=0x55, mem_ready low 3 cycles → mem_we=1 and address/data stable 4 cycles, d_ack single pulse, d_rdata unchanged.
- Mid-access reset: assert rst during I_BUSY with mem_ready=0 → no if_ack ever pulses, mem_req low next cycle, state IDLE.
